// File: rtl/alu_arb_pkg.sv
// Shared FSM state type, ALU op encodings and small helpers for alu_arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [2:0] OP_R1  = 3'b000;
    localparam logic [2:0] OP_R2  = 3'b001;
    localparam logic [2:0] OP_R3  = 3'b010;
    localparam logic [2:0] OP_R4  = 3'b011;
    localparam logic [2:0] OP_R5  = 3'b100;
    localparam logic [2:0] OP_R6  = 3'b101;
    localparam logic [2:0] OP_R7  = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    function automatic logic op_legal(input logic [2:0] op);
        return op inside {OP_R1, OP_R2, OP_R3, OP_R4, OP_R5, OP_R6, OP_R7};
    endfunction

    function automatic logic [2:0] onehot_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// One-hot request arbiter for alu_arbiter. Round-robin when ALU_ARB_RR_EN is
// defined; otherwise fixed priority, lowest index wins, with no pointer state.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant
);

    localparam int unsigned NR = NREQ;

`ifdef ALU_ARB_RR_EN
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr;
    int unsigned   ptr_u;
    int unsigned   cand;
    int unsigned   grant_idx;

    assign ptr_u = {{(32-PW){1'b0}}, ptr};

    // Scan from the farthest candidate back to ptr so the last hit is the
    // requester closest to the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            cand = (ptr_u + NR - 1 - k) % NR;
            if (req[PW'(cand)]) begin
                grant             = '0;
                grant[PW'(cand)]  = 1'b1;
                grant_idx         = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= PW'((grant_idx + 1) % NR);
        end
    end
`else
    logic unused_ports;
    logic found;

    assign unused_ports = ^{clk, rst_n, accept};

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (req[k] && !found) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters with a fixed two-cycle
// grant-to-response latency. Define ALU_ARB_RR_EN for round-robin arbitration.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*3-1:0] req_op,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [2:0]        alu_selec,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    input  logic [N-1:0]      alu_result,
    output logic              rsp_valid,
    output logic [2:0]        rsp_id,
    output logic [N-1:0]      rsp_result,
    output logic              rsp_err,
    input  logic              rsp_ready
);

    state_t          state;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [2:0]      sel_op;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic [2:0]      sel_id;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // The acceptance pulse must coincide with the sampled request, so it is
    // the only output decoded combinationally from state.
    assign accept    = rst_n && (state == IDLE) && (|req_valid);
    assign req_ready = accept ? grant : '0;
    assign sel_id    = onehot_index(8'(grant));

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[i*3 +: 3];
                sel_a  = req_a[i*N +: N];
                sel_b  = req_b[i*N +: N];
            end
        end
    end

    // The alu_* registers double as the latched request: they are loaded on
    // grant and hold for the single ISSUE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_selec  <= OP_NOP;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id <= sel_id;
                        if (op_legal(sel_op)) begin
                            state     <= ISSUE;
                            alu_selec <= sel_op;
                            alu_a     <= sel_a;
                            alu_b     <= sel_b;
                            rsp_err   <= 1'b0;
                        end else begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state      <= RESP;
                    rsp_result <= alu_result;
                    rsp_valid  <= 1'b1;
                    alu_selec  <= OP_NOP;
                    alu_a      <= '0;
                    alu_b      <= '0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    alu_selec <= OP_NOP;
                    alu_a     <= '0;
                    alu_b     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus hand-written
// arbitration, backpressure and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int N    = 4;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [2:0]        alu_selec;
    logic [N-1:0]      alu_a;
    logic [N-1:0]      alu_b;
    logic [N-1:0]      alu_result;
    logic              rsp_valid;
    logic [2:0]        rsp_id;
    logic [N-1:0]      rsp_result;
    logic              rsp_err;
    logic              rsp_ready;

    alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .alu_selec  (alu_selec),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    // Reference ALU; the NOP code yields a non-zero value so an illegal
    // request that wrongly samples the ALU is visible.
    function automatic logic [N-1:0] alu_model(input logic [2:0] op, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~a;
            3'b110:  return {a[N-2:0], 1'b0};
            default: return N'(10);
        endcase
    endfunction

    assign alu_result = alu_model(alu_selec, alu_a, alu_b);

    typedef struct packed {
        logic [2:0]   id;
        logic [N-1:0] result;
        logic         err;
    } rsp_t;

    typedef struct {
        int unsigned  id;
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         err;
    } vec_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int unsigned i, input logic [2:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b);
        req_op[i*3 +: 3] = op;
        req_a[i*N +: N]  = a;
        req_b[i*N +: N]  = b;
    endtask

    task automatic push_exp(input int unsigned id, input logic [N-1:0] res, input logic err);
        rsp_t e;
        e.id     = 3'(id);
        e.result = res;
        e.err    = err;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input string name, output logic [NREQ-1:0] g, output int waited);
        g      = '0;
        waited = 0;
        for (int c = 0; c < 12; c++) begin
            if (req_ready != '0) begin
                g      = req_ready;
                waited = c;
                return;
            end
            tick();
            settle();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no req_ready within 12 cycles, expected a grant", name);
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    // Scoreboard: every accepted response is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got id %0d result 0x%0h, expected no response", rsp_id,
                         rsp_result);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("sb_id", 32'(rsp_id), 32'(e.id));
                chk("sb_result", 32'(rsp_result), 32'(e.result));
                chk("sb_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t            vt[9];
        int unsigned     exp_order[5];
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] exp_g;
        int              waited;

        vt[0] = '{1, 3'b001, 4'h3, 4'h5, 4'hE, 1'b0};
        vt[1] = '{0, 3'b000, 4'h9, 4'h8, 4'h1, 1'b0};
        vt[2] = '{3, 3'b010, 4'hC, 4'hA, 4'h8, 1'b0};
        vt[3] = '{2, 3'b011, 4'h5, 4'hA, 4'hF, 1'b0};
        vt[4] = '{1, 3'b100, 4'hF, 4'h3, 4'hC, 1'b0};
        vt[5] = '{0, 3'b101, 4'h6, 4'h0, 4'h9, 1'b0};
        vt[6] = '{3, 3'b110, 4'h9, 4'h0, 4'h2, 1'b0};
        vt[7] = '{2, 3'b111, 4'h7, 4'h7, 4'h0, 1'b1};
        vt[8] = '{3, 3'b111, 4'h0, 4'h0, 4'h0, 1'b1};

`ifdef ALU_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif

        // Reset with every requester asserting: nothing may be accepted.
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_valid = '1;
        tick();
        settle();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_result", 32'(rsp_result), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_alu_selec", 32'(alu_selec), 7);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_b", 32'(alu_b), 0);
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        settle();

        // Arbitration order with all requesters held, pointer fresh from reset.
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 3'b000, N'(i + 1), 4'h2);
        for (int k = 0; k < 5; k++) push_exp(exp_order[k], N'(exp_order[k] + 3), 1'b0);
        tick();
        req_valid = '1;
        settle();
        for (int k = 0; k < 5; k++) begin
            wait_grant("arb_grant", g, waited);
            chk("arb_order", 32'(idx_of(g)), exp_order[k]);
            if (k > 0) chk("arb_spacing", 32'(waited), 2);
            tick();
            settle();
        end
        req_valid = '0;
        repeat (4) begin
            tick();
            settle();
        end

        // Vector table: one requester at a time, exact cycle timing.
        for (int v = 0; v < 9; v++) begin
            set_req(vt[v].id, vt[v].op, vt[v].a, vt[v].b);
            push_exp(vt[v].id, vt[v].res, vt[v].err);
            exp_g             = '0;
            exp_g[vt[v].id]   = 1'b1;
            tick();
            req_valid          = '0;
            req_valid[vt[v].id] = 1'b1;
            settle();
            chk("v_grant", 32'(req_ready), 32'(exp_g));
            chk("v_t0_alu_selec", 32'(alu_selec), 7);
            chk("v_t0_rsp_valid", 32'(rsp_valid), 0);
            tick();
            req_valid = '0;
            settle();
            chk("v_t1_req_ready", 32'(req_ready), 0);
            if (!vt[v].err) begin
                chk("v_t1_alu_selec", 32'(alu_selec), 32'(vt[v].op));
                chk("v_t1_alu_a", 32'(alu_a), 32'(vt[v].a));
                chk("v_t1_alu_b", 32'(alu_b), 32'(vt[v].b));
                chk("v_t1_rsp_valid", 32'(rsp_valid), 0);
            end else begin
                chk("ill_t1_rsp_valid", 32'(rsp_valid), 1);
                chk("ill_t1_rsp_err", 32'(rsp_err), 1);
                chk("ill_t1_rsp_result", 32'(rsp_result), 0);
                chk("ill_t1_rsp_id", 32'(rsp_id), vt[v].id);
                chk("ill_t1_alu_selec", 32'(alu_selec), 7);
                chk("ill_t1_alu_a", 32'(alu_a), 0);
            end
            tick();
            settle();
            if (!vt[v].err) begin
                chk("v_t2_rsp_valid", 32'(rsp_valid), 1);
                chk("v_t2_rsp_id", 32'(rsp_id), vt[v].id);
                chk("v_t2_alu_selec", 32'(alu_selec), 7);
            end else begin
                chk("ill_t2_rsp_valid", 32'(rsp_valid), 0);
                chk("ill_t2_alu_selec", 32'(alu_selec), 7);
            end
            tick();
            settle();
        end

        // Backpressure: response held for 5 cycles while another request waits.
        set_req(2, 3'b011, 4'h1, 4'h4);
        set_req(0, 3'b000, 4'h2, 4'h2);
        push_exp(2, 4'h5, 1'b0);
        push_exp(0, 4'h4, 1'b0);
        tick();
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        settle();
        chk("bp_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0001;
        settle();
        chk("bp_issue_req_ready", 32'(req_ready), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            settle();
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_id", 32'(rsp_id), 2);
            chk("bp_rsp_result", 32'(rsp_result), 5);
            chk("bp_rsp_err", 32'(rsp_err), 0);
            chk("bp_req_ready", 32'(req_ready), 0);
        end
        tick();
        rsp_ready = 1'b1;
        settle();
        chk("bp_release_rsp_valid", 32'(rsp_valid), 1);
        chk("bp_release_req_ready", 32'(req_ready), 0);
        tick();
        settle();
        chk("bp_regrant", 32'(req_ready), 32'h1);
        chk("bp_idle_rsp_valid", 32'(rsp_valid), 0);
        tick();
        req_valid = '0;
        settle();
        repeat (3) begin
            tick();
            settle();
        end

        // Reset while in ISSUE: in-flight op discarded, no response.
        set_req(1, 3'b000, 4'h1, 4'h1);
        tick();
        req_valid = 4'b0010;
        settle();
        chk("mr_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        settle();
        chk("mr_issue_alu_selec", 32'(alu_selec), 0);
        rst_n = 1'b0;
        tick();
        settle();
        chk("mr_rsp_valid", 32'(rsp_valid), 0);
        chk("mr_rsp_id", 32'(rsp_id), 0);
        chk("mr_rsp_result", 32'(rsp_result), 0);
        chk("mr_rsp_err", 32'(rsp_err), 0);
        chk("mr_alu_selec", 32'(alu_selec), 7);
        chk("mr_alu_a", 32'(alu_a), 0);
        chk("mr_alu_b", 32'(alu_b), 0);
        chk("mr_req_ready", 32'(req_ready), 0);
        tick();
        rst_n = 1'b1;
        settle();
        repeat (4) begin
            tick();
            settle();
            chk("mr_no_rsp", 32'(rsp_valid), 0);
        end

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 4: ALU operand/result width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port req_valid, input, NREQ: per-requester operation request.
REQ-006 Port req_op, input, NREQ x 3: per-requester ALU select code.
REQ-007 Port req_a / req_b, input, NREQ x N each: per-requester operands.
REQ-008 Port req_ready, output, NREQ: one-hot acceptance pulse.
REQ-009 Port alu_selec, output, 3: select code driven to the shared ALU.
REQ-010 Port alu_a / alu_b, output, N each: operands driven to the shared ALU.
REQ-011 Port alu_result, input, N: combinational ALU result.
REQ-012 Port rsp_valid, output, 1: response available.
REQ-013 Port rsp_id, output, 3: index of the requester being answered.
REQ-014 Port rsp_result, output, N: captured result.
REQ-015 Port rsp_err, output, 1: set when the request used an illegal op.
REQ-016 Port rsp_ready, input, 1: response consumer accepts.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-018 In IDLE with any req_valid set, the block SHALL grant one requester, pulse its req_ready for exactly that cycle and latch its op, a and b.
REQ-019 A granted legal op (3'b000..3'b110) SHALL go IDLE->ISSUE; in ISSUE alu_selec/alu_a/alu_b come from the latched values, and alu_result is registered into rsp_result at the end of ISSUE.
REQ-020 ISSUE SHALL always go to RESP after one cycle; rsp_valid=1 in RESP only.
REQ-021 Latency SHALL be fixed: a grant in cycle T gives rsp_valid=1 in cycle T+2.
REQ-022 A granted op 3'b111 SHALL go IDLE->RESP directly with rsp_err=1 and rsp_result=0, and SHALL NOT drive the ALU.
REQ-023 In RESP, rsp_valid, rsp_id, rsp_result and rsp_err SHALL hold stable until rsp_ready=1; that cycle goes to IDLE.
REQ-024 No grant SHALL occur outside IDLE; req_ready is all-zero in ISSUE and RESP, so throughput is at most one op per 3 cycles.
REQ-025 Outside ISSUE, alu_selec SHALL be 3'b111 (no operation) and alu_a/alu_b SHALL be 0.
REQ-026 Requesters SHALL hold req_valid/op/a/b stable until accepted; a req_valid dropped before grant is simply not served.
REQ-027 The index width of rsp_id SHALL be zero-extended to 3 bits; no arithmetic is performed on operands.

Reset
REQ-028 While rst_n=0 at a clock edge: state becomes IDLE; req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, alu_selec=3'b111, alu_a=0, alu_b=0; the priority pointer resets to 0.
REQ-029 Reset in ISSUE or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-030 With macro ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: after a grant to i, the highest priority goes to (i+1) mod NREQ.
REQ-031 Without ALU_ARB_RR_EN, arbitration SHALL be fixed priority with the lowest index winning; no pointer register exists.

Structure
REQ-032 Package alu_arb_pkg SHALL hold the state enum (IDLE/ISSUE/RESP), the op constants OP_R1..OP_R7 (3'b000..3'b110) and OP_NOP (3'b111).
REQ-033 Grant selection SHALL be a sub-module rr_arbiter (request vector in, one-hot grant out, pointer update on accept), holding the ALU_ARB_RR_EN logic.

Verification
REQ-034 Single request: req_valid=4'b0010, op=3'b001, a=4'h3, b=4'h5 -> req_ready[1] pulses at T; alu_selec=001 at T+1; rsp_valid with rsp_id=1 and rsp_result equal to the ALU value at T+2.
REQ-035 Round-robin (ALU_ARB_RR_EN): req_valid=4'b1111 held -> grant order 0,1,2,3,0; without the macro -> 0,0,0.
REQ-036 Illegal op: op=3'b111 from requester 2 -> rsp_valid at T+1 with rsp_err=1 and rsp_result=0; alu_selec stays 3'b111 throughout.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, no req_ready pulses; rsp_ready=1 -> IDLE next cycle, next grant the cycle after.
REQ-038 Reset mid-op: rst_n=0 during ISSUE -> next cycle IDLE with all outputs at their reset values and no response issued.
